// File: rtl/mac_unit.sv
// Multiply-accumulate cell for the 3x3 systolic matrix multiplier.
// A and B are forwarded through one register stage, and their product is added into C.
module mac_unit #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] pass_A,
    output logic [DATA_W-1:0] pass_B,
    output logic [ACC_W-1:0]  C
);

    localparam int PROD_W = 2 * DATA_W;
    // One spare bit above the wider of accumulator and product so a saturating sum never overflows.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

    logic [PROD_W-1:0] product;
    logic [SUM_W-1:0]  sum;
    logic [ACC_W-1:0]  c_d, c_q;
    logic [DATA_W-1:0] pass_a_d, pass_a_q;
    logic [DATA_W-1:0] pass_b_d, pass_b_q;

    always_comb begin
        product  = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
        sum      = SUM_W'(c_q) + SUM_W'(product);
        pass_a_d = A;
        pass_b_d = B;
        c_d      = sum[ACC_W-1:0];
        if (SATURATE && (sum > ACC_MAX)) begin
            c_d = {ACC_W{1'b1}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_q      <= '0;
            pass_a_q <= '0;
            pass_b_q <= '0;
        end else begin
            c_q      <= c_d;
            pass_a_q <= pass_a_d;
            pass_b_q <= pass_b_d;
        end
    end

    assign C      = c_q;
    assign pass_A = pass_a_q;
    assign pass_B = pass_b_q;

endmodule

// File: tb/tb_mac_unit.sv
// Bench for mac_unit: directed and random single-cell checks, plus a 3x3 systolic array built from nine cells.
module tb_mac_unit;

    logic       clk;
    logic       reset;
    logic [7:0] a_in, b_in;
    logic [7:0] wrap_pass_a, wrap_pass_b, wrap_c;
    logic [7:0] sat_pass_a, sat_pass_b, sat_c;

    int checks;
    int passes;

    logic [7:0] row_in [3];
    logic [7:0] col_in [3];
    logic [7:0] ain [3][3];
    logic [7:0] bin [3][3];
    logic [7:0] pa  [3][3];
    logic [7:0] pb  [3][3];
    logic [7:0] cc  [3][3];

    int mat_a [3][3];
    int mat_b [3][3];

    mac_unit #(.DATA_W(8), .ACC_W(8), .SATURATE(1'b0)) dut (
        .clk(clk), .reset(reset), .A(a_in), .B(b_in),
        .pass_A(wrap_pass_a), .pass_B(wrap_pass_b), .C(wrap_c)
    );

    mac_unit #(.DATA_W(8), .ACC_W(8), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .A(a_in), .B(b_in),
        .pass_A(sat_pass_a), .pass_B(sat_pass_b), .C(sat_c)
    );

    genvar gi, gj;
    for (gi = 0; gi < 3; gi++) begin : g_row
        for (gj = 0; gj < 3; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign ain[gi][gj] = row_in[gi];
            end else begin : g_a_chain
                assign ain[gi][gj] = pa[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign bin[gi][gj] = col_in[gj];
            end else begin : g_b_chain
                assign bin[gi][gj] = pb[gi-1][gj];
            end
            mac_unit #(.DATA_W(8), .ACC_W(8), .SATURATE(1'b0)) u_cell (
                .clk(clk), .reset(reset), .A(ain[gi][gj]), .B(bin[gi][gj]),
                .pass_A(pa[gi][gj]), .pass_B(pb[gi][gj]), .C(cc[gi][gj])
            );
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land 1ns after it, where outputs are sampled and inputs re-driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        a_in  = 8'd0;
        b_in  = 8'd0;
        for (int i = 0; i < 3; i++) begin
            row_in[i] = 8'd0;
            col_in[i] = 8'd0;
        end
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        a_in = 8'd0;
        b_in = 8'd0;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (wrap_c !== 8'd0) $display("[TB] FAIL reset_async_c: got %0d expected 0", wrap_c);
        else passes++;
        a_in = 8'd9;
        b_in = 8'd9;
        step();
        step();
        step();
        checks++;
        if (wrap_c !== 8'd0) $display("[TB] FAIL reset_held_c: got %0d expected 0", wrap_c);
        else passes++;
        checks++;
        if (wrap_pass_a !== 8'd0 || wrap_pass_b !== 8'd0)
            $display("[TB] FAIL reset_held_pass: got %0d/%0d expected 0/0", wrap_pass_a, wrap_pass_b);
        else passes++;
        reset = 1'b1;
        #2;
        checks++;
        if (wrap_c !== 8'd0 || wrap_pass_a !== 8'd0 || wrap_pass_b !== 8'd0)
            $display("[TB] FAIL reset_release_no_edge: got c=%0d pa=%0d pb=%0d expected 0", wrap_c, wrap_pass_a, wrap_pass_b);
        else passes++;
    endtask

    task automatic test_basic_mac();
        pulse_reset();
        a_in = 8'd3;
        b_in = 8'd4;
        step();
        checks++;
        if (wrap_c !== 8'd12 || wrap_pass_a !== 8'd3 || wrap_pass_b !== 8'd4)
            $display("[TB] FAIL basic_first: got c=%0d pa=%0d pb=%0d expected 12/3/4", wrap_c, wrap_pass_a, wrap_pass_b);
        else passes++;
        a_in = 8'd5;
        b_in = 8'd6;
        step();
        checks++;
        if (wrap_c !== 8'd42 || wrap_pass_a !== 8'd5 || wrap_pass_b !== 8'd6)
            $display("[TB] FAIL basic_second: got c=%0d pa=%0d pb=%0d expected 42/5/6", wrap_c, wrap_pass_a, wrap_pass_b);
        else passes++;
    endtask

    task automatic test_zero_hold_async_reset();
        a_in = 8'd0;
        b_in = 8'd7;
        step();
        checks++;
        if (wrap_c !== 8'd42 || wrap_pass_a !== 8'd0 || wrap_pass_b !== 8'd7)
            $display("[TB] FAIL zero_hold: got c=%0d pa=%0d pb=%0d expected 42/0/7", wrap_c, wrap_pass_a, wrap_pass_b);
        else passes++;
        a_in = 8'd2;
        b_in = 8'd2;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (wrap_c !== 8'd0 || wrap_pass_a !== 8'd0 || wrap_pass_b !== 8'd0)
            $display("[TB] FAIL midrun_async_reset: got c=%0d pa=%0d pb=%0d expected 0/0/0", wrap_c, wrap_pass_a, wrap_pass_b);
        else passes++;
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_wrap();
        pulse_reset();
        a_in = 8'd255;
        b_in = 8'd255;
        step();
        checks++;
        if (wrap_c !== 8'd1) $display("[TB] FAIL wrap_big: got %0d expected 1", wrap_c);
        else passes++;
        a_in = 8'd16;
        b_in = 8'd16;
        step();
        checks++;
        if (wrap_c !== 8'd1) $display("[TB] FAIL wrap_256: got %0d expected 1", wrap_c);
        else passes++;
    endtask

    task automatic test_saturate();
        pulse_reset();
        a_in = 8'd255;
        b_in = 8'd255;
        step();
        checks++;
        if (sat_c !== 8'd255) $display("[TB] FAIL sat_big: got %0d expected 255", sat_c);
        else passes++;
        a_in = 8'd1;
        b_in = 8'd1;
        step();
        checks++;
        if (sat_c !== 8'd255) $display("[TB] FAIL sat_hold_max: got %0d expected 255", sat_c);
        else passes++;
        pulse_reset();
        a_in = 8'd10;
        b_in = 8'd20;
        step();
        checks++;
        if (sat_c !== 8'd200) $display("[TB] FAIL sat_below_max: got %0d expected 200", sat_c);
        else passes++;
    endtask

    task automatic test_random();
        int exp_wrap, exp_sat, av, bv, errs;
        pulse_reset();
        exp_wrap = 0;
        exp_sat  = 0;
        errs     = 0;
        for (int n = 0; n < 200; n++) begin
            av = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            bv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15));
            if (n % 50 == 0) begin
                exp_sat = 0;
                pulse_reset();
            end
            a_in = 8'(av);
            b_in = 8'(bv);
            step();
            exp_wrap = (n % 50 == 0) ? (av * bv) % 256 : (exp_wrap + av * bv) % 256;
            exp_sat  = (exp_sat + av * bv > 255) ? 255 : exp_sat + av * bv;
            checks++;
            if (wrap_c !== 8'(exp_wrap) || sat_c !== 8'(exp_sat) ||
                wrap_pass_a !== 8'(av) || wrap_pass_b !== 8'(bv) ||
                sat_pass_a !== 8'(av) || sat_pass_b !== 8'(bv)) begin
                if (errs < 5)
                    $display("[TB] FAIL random_step%0d: got c=%0d sat=%0d pa=%0d pb=%0d expected %0d/%0d/%0d/%0d",
                             n, wrap_c, sat_c, wrap_pass_a, wrap_pass_b, exp_wrap, exp_sat, av, bv);
                errs++;
            end else passes++;
        end
    endtask

    // Feeds mat_a rows from the left and mat_b columns from the top, row i and column j skewed by i and j cycles.
    task automatic run_array(input string tag);
        int exp_v;
        pulse_reset();
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 3; i++) begin
                row_in[i] = (t - i >= 0 && t - i < 3) ? 8'(mat_a[i][t-i]) : 8'd0;
                col_in[i] = (t - i >= 0 && t - i < 3) ? 8'(mat_b[t-i][i]) : 8'd0;
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                exp_v = 0;
                for (int k = 0; k < 3; k++) exp_v += mat_a[i][k] * mat_b[k][j];
                exp_v = exp_v % 256;
                checks++;
                if (cc[i][j] !== 8'(exp_v))
                    $display("[TB] FAIL array_%s_c%0d%0d: got %0d expected %0d", tag, i, j, cc[i][j], exp_v);
                else passes++;
            end
        end
    endtask

    task automatic test_array();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                mat_a[i][j] = i * 3 + j + 1;
                mat_b[i][j] = (i == j) ? 1 : 0;
            end
        run_array("identity");
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                mat_a[i][j] = 2;
                mat_b[i][j] = 2;
            end
        run_array("all2");
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                mat_a[i][j] = int'($urandom_range(1, 255));
                mat_b[i][j] = int'($urandom_range(1, 255));
            end
        run_array("random");
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset  = 1'b1;
        a_in   = 8'd0;
        b_in   = 8'd0;
        for (int i = 0; i < 3; i++) begin
            row_in[i] = 8'd0;
            col_in[i] = 8'd0;
        end
        #2;
        test_reset();
        test_basic_mac();
        test_zero_hold_async_reset();
        test_wrap();
        test_saturate();
        test_random();
        test_array();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
